mem_wb_pipe_reg: RTL and testbench
==================================

# mem_wb_pipe_reg

Parametrised MEM/WB pipeline register for the MIPS datapath, the successor to the fixed 32-bit MEM stage register. It carries write-back control, ALU result, memory read value and destination register from MEM to WB using a valid/ready handshake. It supports stall and flush, and an optional 2-entry skid buffer. It also produces a pre-muxed write-back value and a forwarding tap for the hazard unit.

## Interface
Parameters:
- DATA_W, 32, width of ALU_result / Mem_read_value / WB_value
- DEST_W, 5, width of destination register index

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- flush  in  1  synchronous discard of all held entries
- in_valid  in  1  MEM stage presents an entry
- in_ready  out  1  register can accept an entry this cycle
- WB_en_in, MEM_R_EN_in  in  1 each  control from MEM
- ALU_result_in, Mem_read_value_in  in  DATA_W each  data from MEM
- Dest_in  in  DEST_W  destination register
- out_valid  out  1  head entry valid toward WB
- out_ready  in  1  WB consumes head entry
- WB_en, MEM_R_EN  out  1 each  head control (WB_en qualified, see Operation)
- ALU_result, Mem_read_value  out  DATA_W each  head data
- Dest  out  DEST_W  head destination
- WB_value  out  DATA_W  MEM_R_EN ? Mem_read_value : ALU_result
- fwd_valid  out  1  out_valid & WB_en
- fwd_dest  out  DEST_W  equals Dest
- fwd_value  out  DATA_W  equals WB_value
- occupancy  out  2  held entries, 0..2 (0..1 without skid)

## Operation
- Accept is in_valid & in_ready. Retire is out_valid & out_ready.
- Head register drives all outputs. Skid register is present only with MEMWB_SKID_EN.
- Skid mode transitions:
  - Empty + accept → head loaded.
  - Head only: accept without retire → skid loaded. Accept with retire → head reloaded from input.
  - Head+skid: retire → skid moves to head. Accept is impossible because in_ready=0.
- WB_en output = stored WB_en & (Dest != 0). Writes to $zero are suppressed at capture.
- Data fields are don't-care semantically when out_valid=0. They hold the last value; they are never driven to z or x.
- flush: next cycle occupancy=0 and out_valid=0. A simultaneous accept is dropped. A simultaneous retire still counts as consumed by WB.
- rst low: next edge all outputs 0, including in_ready=0 while rst is held low. First cycle after release: in_ready=1, occupancy=0.
- rst has priority over flush; flush has priority over accept/retire.

## Timing
- Latency 1 cycle: accept at edge N → out_valid=1 with that entry after edge N.
- Throughput 1 entry/cycle sustained with out_ready=1.
- Skid mode: in_ready is registered, equal to !skid_valid. There is no combinational path from out_ready to in_ready.
- No-skid mode: in_ready = rst & (!out_valid | out_ready), which is combinational.
- fwd_* and WB_value are combinational from head registers only. They never depend on *_in.
- No ordering change: entries retire in accept order.

## Configuration
- MEMWB_SKID_EN defined: 2-entry buffer, registered in_ready, occupancy up to 2.
- MEMWB_SKID_EN undefined: single head register, combinational in_ready, occupancy bit 1 tied 0.
- Ports and parameters are identical in both builds.

## Test plan
- Reset: rst=0 for 2 cycles with in_valid=1 → all outputs 0, in_ready=0. After release, in_ready=1, occupancy=0.
- Streaming: 8 back-to-back entries with ALU_result=0x10..0x17, out_ready=1 → each appears 1 cycle after accept, in order, occupancy stays 1.
- Stall (skid): out_ready=0, push A=0xAAAA_0001 then B=0xBBBB_0002 → occupancy=2, in_ready=0. Raise out_ready → A then B retire on consecutive cycles.
- Write-back mux / zero dest:
  - MEM_R_EN=1, Mem_read_value=0xDEAD_BEEF, ALU_result=0x4 → WB_value=0xDEADBEEF.
  - Dest=0, WB_en_in=1 → WB_en=0, fwd_valid=0.
- Flush: occupancy=2, assert flush with in_valid=1 → next cycle occupancy=0, out_valid=0, dropped input never appears.
- Reset mid-stall: occupancy=2, rst=0 one cycle → all outputs 0. Entries are not replayed after release.

Source files
------------

// File: rtl/mem_wb_pipe_reg.sv
// ---------------------------------------------------------------------------
// mem_wb_pipe_reg
//
// MEM/WB pipeline register for the MIPS datapath with a valid/ready handshake.
// It carries the write-back control, the ALU result, the memory read value and
// the destination register from MEM to WB. It also drives a pre-muxed
// write-back value and a forwarding tap for the hazard unit.
//
// Build option:
//   MEMWB_SKID_EN  defined   -> 2-entry buffer (head + skid). in_ready is
//                               derived from the skid state only, so there is
//                               no path from out_ready to in_ready.
//                  undefined -> single head register. in_ready is
//                               combinational: rst & (!out_valid | out_ready).
//
// Parameters:
//   DATA_W  width of the ALU result, memory read value and WB value
//   DEST_W  width of the destination register index
//
// Ports:
//   clk, rst              clock; synchronous active-low reset
//   flush                 synchronous discard of all held entries
//   in_valid/in_ready     MEM-side handshake
//   WB_en_in, MEM_R_EN_in, ALU_result_in, Mem_read_value_in, Dest_in
//                         entry fields from MEM
//   out_valid/out_ready   WB-side handshake
//   WB_en, MEM_R_EN, ALU_result, Mem_read_value, Dest
//                         head entry fields
//   WB_value              MEM_R_EN ? Mem_read_value : ALU_result
//   fwd_valid/dest/value  forwarding tap, taken from the head register only
//   occupancy             number of held entries (0..2)
// ---------------------------------------------------------------------------
module mem_wb_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              WB_en_in,
    input  logic              MEM_R_EN_in,
    input  logic [DATA_W-1:0] ALU_result_in,
    input  logic [DATA_W-1:0] Mem_read_value_in,
    input  logic [DEST_W-1:0] Dest_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              WB_en,
    output logic              MEM_R_EN,
    output logic [DATA_W-1:0] ALU_result,
    output logic [DATA_W-1:0] Mem_read_value,
    output logic [DEST_W-1:0] Dest,
    output logic [DATA_W-1:0] WB_value,
    output logic              fwd_valid,
    output logic [DEST_W-1:0] fwd_dest,
    output logic [DATA_W-1:0] fwd_value,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } occ_state_t;

    occ_state_t state_q, state_d;

    // Head entry: drives every output.
    logic              head_wb_en_q;
    logic              head_mem_r_en_q;
    logic [DATA_W-1:0] head_alu_q;
    logic [DATA_W-1:0] head_mem_q;
    logic [DEST_W-1:0] head_dest_q;

    logic accept;
    logic retire;
    logic load_head_in;   // head <= input entry

    // Writes to $zero are dropped when the entry is captured.
    logic wb_en_qual_in;
    assign wb_en_qual_in = WB_en_in & (|Dest_in);

    assign out_valid = (state_q != S_EMPTY);
    assign accept    = in_valid & in_ready;
    assign retire    = out_valid & out_ready;

`ifdef MEMWB_SKID_EN
    logic              skid_wb_en_q;
    logic              skid_mem_r_en_q;
    logic [DATA_W-1:0] skid_alu_q;
    logic [DATA_W-1:0] skid_mem_q;
    logic [DEST_W-1:0] skid_dest_q;
    logic              load_skid_in;   // skid <= input entry
    logic              move_skid;      // head <= skid

    // Depends only on the skid state; rst only forces it low in reset.
    assign in_ready = rst & (state_q != S_TWO);
`else
    assign in_ready = rst & (!out_valid | out_ready);
`endif

    // Next-state / load control.
    always_comb begin
        state_d      = state_q;
        load_head_in = 1'b0;
`ifdef MEMWB_SKID_EN
        load_skid_in = 1'b0;
        move_skid    = 1'b0;
`endif
        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    load_head_in = 1'b1;
                    state_d      = S_ONE;
                end
            end
            S_ONE: begin
                if (accept && retire) begin
                    load_head_in = 1'b1;
                end else if (accept) begin
`ifdef MEMWB_SKID_EN
                    load_skid_in = 1'b1;
                    state_d      = S_TWO;
`endif
                end else if (retire) begin
                    state_d = S_EMPTY;
                end
            end
`ifdef MEMWB_SKID_EN
            S_TWO: begin
                // in_ready is low here, so only a retire can happen.
                if (retire) begin
                    move_skid = 1'b1;
                    state_d   = S_ONE;
                end
            end
`endif
            default: state_d = S_EMPTY;
        endcase

        // Flush discards everything, including a same-cycle accept. A
        // same-cycle retire has already been seen by WB.
        if (flush) begin
            state_d      = S_EMPTY;
            load_head_in = 1'b0;
`ifdef MEMWB_SKID_EN
            load_skid_in = 1'b0;
            move_skid    = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= S_EMPTY;
            head_wb_en_q    <= 1'b0;
            head_mem_r_en_q <= 1'b0;
            head_alu_q      <= '0;
            head_mem_q      <= '0;
            head_dest_q     <= '0;
`ifdef MEMWB_SKID_EN
            skid_wb_en_q    <= 1'b0;
            skid_mem_r_en_q <= 1'b0;
            skid_alu_q      <= '0;
            skid_mem_q      <= '0;
            skid_dest_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            // Data fields hold their last value when not loaded.
            if (load_head_in) begin
                head_wb_en_q    <= wb_en_qual_in;
                head_mem_r_en_q <= MEM_R_EN_in;
                head_alu_q      <= ALU_result_in;
                head_mem_q      <= Mem_read_value_in;
                head_dest_q     <= Dest_in;
            end
`ifdef MEMWB_SKID_EN
            else if (move_skid) begin
                head_wb_en_q    <= skid_wb_en_q;
                head_mem_r_en_q <= skid_mem_r_en_q;
                head_alu_q      <= skid_alu_q;
                head_mem_q      <= skid_mem_q;
                head_dest_q     <= skid_dest_q;
            end
            if (load_skid_in) begin
                skid_wb_en_q    <= wb_en_qual_in;
                skid_mem_r_en_q <= MEM_R_EN_in;
                skid_alu_q      <= ALU_result_in;
                skid_mem_q      <= Mem_read_value_in;
                skid_dest_q     <= Dest_in;
            end
`endif
        end
    end

    // All outputs come from the head register only.
    assign WB_en          = head_wb_en_q & (|head_dest_q);
    assign MEM_R_EN       = head_mem_r_en_q;
    assign ALU_result     = head_alu_q;
    assign Mem_read_value = head_mem_q;
    assign Dest           = head_dest_q;
    assign WB_value       = head_mem_r_en_q ? head_mem_q : head_alu_q;

    assign fwd_valid = out_valid & WB_en;
    assign fwd_dest  = head_dest_q;
    assign fwd_value = WB_value;

    assign occupancy = (state_q == S_TWO) ? 2'd2 :
                       (state_q == S_ONE) ? 2'd1 : 2'd0;

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_pipe_reg
//
// Directed testbench for mem_wb_pipe_reg. A vector table covers streaming,
// the write-back mux and zero-destination suppression. Hand-written sequences
// cover reset, stall/skid, flush and reset during a stall. Expectations that
// differ between the two builds are selected with MEMWB_SKID_EN.
// ---------------------------------------------------------------------------
module tb_mem_wb_pipe_reg;

    localparam int DATA_W = 32;
    localparam int DEST_W = 5;
    localparam int NVEC   = 13;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic              WB_en_in;
    logic              MEM_R_EN_in;
    logic [DATA_W-1:0] ALU_result_in;
    logic [DATA_W-1:0] Mem_read_value_in;
    logic [DEST_W-1:0] Dest_in;
    logic              out_valid;
    logic              out_ready;
    logic              WB_en;
    logic              MEM_R_EN;
    logic [DATA_W-1:0] ALU_result;
    logic [DATA_W-1:0] Mem_read_value;
    logic [DEST_W-1:0] Dest;
    logic [DATA_W-1:0] WB_value;
    logic              fwd_valid;
    logic [DEST_W-1:0] fwd_dest;
    logic [DATA_W-1:0] fwd_value;
    logic [1:0]        occupancy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_wb_pipe_reg #(.DATA_W(DATA_W), .DEST_W(DEST_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .WB_en_in          (WB_en_in),
        .MEM_R_EN_in       (MEM_R_EN_in),
        .ALU_result_in     (ALU_result_in),
        .Mem_read_value_in (Mem_read_value_in),
        .Dest_in           (Dest_in),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .WB_en             (WB_en),
        .MEM_R_EN          (MEM_R_EN),
        .ALU_result        (ALU_result),
        .Mem_read_value    (Mem_read_value),
        .Dest              (Dest),
        .WB_value          (WB_value),
        .fwd_valid         (fwd_valid),
        .fwd_dest          (fwd_dest),
        .fwd_value         (fwd_value),
        .occupancy         (occupancy)
    );

    typedef struct {
        logic        vld;
        logic        ordy;
        logic        wb;
        logic        mr;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [4:0]  dst;
        logic        e_vld;
        logic        e_wb;
        logic        e_mr;
        logic [31:0] e_alu;
        logic [31:0] e_mem;
        logic [4:0]  e_dst;
        logic [31:0] e_wbv;
        logic [1:0]  e_occ;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic wb, input logic mr,
                         input logic [31:0] alu, input logic [31:0] mem, input logic [4:0] dst);
        in_valid          = v;
        WB_en_in          = wb;
        MEM_R_EN_in       = mr;
        ALU_result_in     = alu;
        Mem_read_value_in = mem;
        Dest_in           = dst;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, ".in_ready"},  {31'd0, in_ready},  32'd0);
        chk({tag, ".WB_en"},     {31'd0, WB_en},     32'd0);
        chk({tag, ".MEM_R_EN"},  {31'd0, MEM_R_EN},  32'd0);
        chk({tag, ".ALU_result"}, ALU_result, 32'd0);
        chk({tag, ".Mem_read_value"}, Mem_read_value, 32'd0);
        chk({tag, ".Dest"},      {27'd0, Dest},      32'd0);
        chk({tag, ".WB_value"},  WB_value,  32'd0);
        chk({tag, ".fwd_valid"}, {31'd0, fwd_valid}, 32'd0);
        chk({tag, ".fwd_dest"},  {27'd0, fwd_dest},  32'd0);
        chk({tag, ".fwd_value"}, fwd_value, 32'd0);
        chk({tag, ".occupancy"}, {30'd0, occupancy}, 32'd0);
    endtask

    function automatic vec_t mk(input logic v, input logic ordy, input logic wb, input logic mr,
                                input logic [31:0] alu, input logic [31:0] mem, input logic [4:0] dst,
                                input logic ev, input logic ewb, input logic emr,
                                input logic [31:0] ealu, input logic [31:0] emem, input logic [4:0] edst,
                                input logic [31:0] ewbv, input logic [1:0] eocc);
        vec_t r;
        r.vld = v; r.ordy = ordy; r.wb = wb; r.mr = mr;
        r.alu = alu; r.mem = mem; r.dst = dst;
        r.e_vld = ev; r.e_wb = ewb; r.e_mr = emr;
        r.e_alu = ealu; r.e_mem = emem; r.e_dst = edst;
        r.e_wbv = ewbv; r.e_occ = eocc;
        return r;
    endfunction

    initial begin
        // ---- vector table ----
        for (int i = 0; i < 8; i++) begin
            vecs[i] = mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h10 + i, 32'h100 + i, 5'(i + 1),
                         1'b1, 1'b1, 1'b0, 32'h10 + i, 32'h100 + i, 5'(i + 1), 32'h10 + i, 2'd1);
        end
        vecs[8]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'h4, 32'hDEAD_BEEF, 5'd3,
                      1'b1, 1'b1, 1'b1, 32'h4, 32'hDEAD_BEEF, 5'd3, 32'hDEAD_BEEF, 2'd1);
        vecs[9]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h55, 32'h66, 5'd0,
                      1'b1, 1'b0, 1'b0, 32'h55, 32'h66, 5'd0, 32'h55, 2'd1);
        vecs[10] = mk(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF, 32'hFFFF, 5'd9,
                      1'b0, 1'b0, 1'b0, 32'h55, 32'h66, 5'd0, 32'h55, 2'd0);
        vecs[11] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h99, 32'h77, 5'd7,
                      1'b1, 1'b0, 1'b0, 32'h99, 32'h77, 5'd7, 32'h99, 2'd1);
        vecs[12] = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0,
                      1'b0, 1'b0, 1'b0, 32'h99, 32'h77, 5'd7, 32'h99, 2'd0);

        // ---- reset held for 2 cycles with in_valid=1 ----
        rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 32'h1234, 32'h5678, 5'd5);
        tick();
        tick();
        chk_all_zero("reset");
        $display("txn reset: out_valid=%0d in_ready=%0d occ=%0d", out_valid, in_ready, occupancy);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        #1;
        chk("release.in_ready", {31'd0, in_ready}, 32'd1);
        chk("release.occupancy", {30'd0, occupancy}, 32'd0);
        $display("txn release: in_ready=%0d occ=%0d", in_ready, occupancy);

        // ---- table-driven vectors ----
        for (int i = 0; i < NVEC; i++) begin
            out_ready = vecs[i].ordy;
            drive(vecs[i].vld, vecs[i].wb, vecs[i].mr, vecs[i].alu, vecs[i].mem, vecs[i].dst);
            tick();
            chk($sformatf("v%0d.out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_vld});
            chk($sformatf("v%0d.WB_en", i), {31'd0, WB_en}, {31'd0, vecs[i].e_wb});
            chk($sformatf("v%0d.MEM_R_EN", i), {31'd0, MEM_R_EN}, {31'd0, vecs[i].e_mr});
            chk($sformatf("v%0d.ALU_result", i), ALU_result, vecs[i].e_alu);
            chk($sformatf("v%0d.Mem_read_value", i), Mem_read_value, vecs[i].e_mem);
            chk($sformatf("v%0d.Dest", i), {27'd0, Dest}, {27'd0, vecs[i].e_dst});
            chk($sformatf("v%0d.WB_value", i), WB_value, vecs[i].e_wbv);
            chk($sformatf("v%0d.occupancy", i), {30'd0, occupancy}, {30'd0, vecs[i].e_occ});
            chk($sformatf("v%0d.fwd_valid", i), {31'd0, fwd_valid},
                {31'd0, vecs[i].e_vld & vecs[i].e_wb});
            chk($sformatf("v%0d.fwd_dest", i), {27'd0, fwd_dest}, {27'd0, vecs[i].e_dst});
            chk($sformatf("v%0d.fwd_value", i), fwd_value, vecs[i].e_wbv);
            $display("txn v%0d: vld=%0d alu=0x%0h -> out_valid=%0d WB_value=0x%0h Dest=%0d occ=%0d",
                     i, vecs[i].vld, vecs[i].alu, out_valid, WB_value, Dest, occupancy);
        end

        // ---- stall: push A then B with out_ready=0 ----
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'hAAAA_0001, 32'h0, 5'd4);
        tick();
        chk("stallA.occupancy", {30'd0, occupancy}, 32'd1);
        chk("stallA.WB_value", WB_value, 32'hAAAA_0001);
`ifdef MEMWB_SKID_EN
        chk("stallA.in_ready", {31'd0, in_ready}, 32'd1);
`else
        chk("stallA.in_ready", {31'd0, in_ready}, 32'd0);
`endif
        drive(1'b1, 1'b1, 1'b0, 32'hBBBB_0002, 32'h0, 5'd6);
        tick();
        chk("stallB.WB_value", WB_value, 32'hAAAA_0001);
`ifdef MEMWB_SKID_EN
        chk("stallB.occupancy", {30'd0, occupancy}, 32'd2);
        chk("stallB.in_ready", {31'd0, in_ready}, 32'd0);
`else
        chk("stallB.occupancy", {30'd0, occupancy}, 32'd1);
`endif
        $display("txn stall: occ=%0d in_ready=%0d head=0x%0h", occupancy, in_ready, WB_value);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        out_ready = 1'b1;
        tick();
`ifdef MEMWB_SKID_EN
        chk("drain1.out_valid", {31'd0, out_valid}, 32'd1);
        chk("drain1.WB_value", WB_value, 32'hBBBB_0002);
        chk("drain1.Dest", {27'd0, Dest}, 32'd6);
        chk("drain1.occupancy", {30'd0, occupancy}, 32'd1);
        $display("txn drain1: out_valid=%0d head=0x%0h", out_valid, WB_value);
        tick();
`endif
        chk("drain2.out_valid", {31'd0, out_valid}, 32'd0);
        chk("drain2.occupancy", {30'd0, occupancy}, 32'd0);
        $display("txn drain2: out_valid=%0d occ=%0d", out_valid, occupancy);

        // ---- flush while full, with a simultaneous input ----
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'hC0C0_0003, 32'h0, 5'd8);
        tick();
`ifdef MEMWB_SKID_EN
        drive(1'b1, 1'b1, 1'b0, 32'hD0D0_0004, 32'h0, 5'd9);
        tick();
        chk("prefl.occupancy", {30'd0, occupancy}, 32'd2);
`else
        chk("prefl.occupancy", {30'd0, occupancy}, 32'd1);
`endif
        flush = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'hEEEE_0005, 32'h0, 5'd10);
        tick();
        flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        chk("flush.occupancy", {30'd0, occupancy}, 32'd0);
        chk("flush.out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush.head_held", WB_value, 32'hC0C0_0003);
        $display("txn flush: occ=%0d out_valid=%0d", occupancy, out_valid);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("postfl%0d.out_valid", k), {31'd0, out_valid}, 32'd0);
            chk($sformatf("postfl%0d.WB_value", k), WB_value, 32'hC0C0_0003);
        end
        $display("txn postflush: out_valid=%0d WB_value=0x%0h", out_valid, WB_value);

        // ---- reset during a stall ----
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 32'hF0F0_0006, 32'h1111_0006, 5'd11);
        tick();
`ifdef MEMWB_SKID_EN
        drive(1'b1, 1'b1, 1'b0, 32'h6060_0007, 32'h0, 5'd12);
        tick();
        chk("prerst.occupancy", {30'd0, occupancy}, 32'd2);
`else
        chk("prerst.occupancy", {30'd0, occupancy}, 32'd1);
`endif
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        rst = 1'b0;
        tick();
        chk_all_zero("midrst");
        $display("txn midreset: out_valid=%0d occ=%0d", out_valid, occupancy);
        rst = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("postrst%0d.out_valid", k), {31'd0, out_valid}, 32'd0);
            chk($sformatf("postrst%0d.occupancy", k), {30'd0, occupancy}, 32'd0);
            chk($sformatf("postrst%0d.in_ready", k), {31'd0, in_ready}, 32'd1);
        end
        $display("txn postreset: out_valid=%0d occ=%0d", out_valid, occupancy);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
